// File: rtl/sig_pkg.sv
// ============================================================================
//  Module   : sig_pkg
//  Brief    : Shared types and default widths for the signal generator family.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sig_pkg;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    GATE  = 1'b1
  } meter_state_t;

  localparam int c_sig_width     = 8;
  localparam int c_sig_gate_bits = 8;
  localparam int c_sig_per_w     = 16;

endpackage

`default_nettype wire

// File: rtl/edge_det.sv
// ============================================================================
//  Module   : edge_det
//  Brief    : MSB rising-edge detector, qualified by sample enable and arm.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  input  logic arm,
  input  logic msb,
  output logic edge_now
);

  logic r_prev_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_msb <= 1'b0;
    end else if (clear) begin
      r_prev_msb <= 1'b0;
    end else if (en) begin
      r_prev_msb <= msb;
    end
  end

  // arm is low while priming, so the first accepted sample only loads history
  assign edge_now = en & arm & ~clear & ~r_prev_msb & msb;

endmodule

`default_nettype wire

// File: rtl/incr_meter.sv
// ============================================================================
//  Module   : incr_meter
//  Brief    : Gated count of rising mid-scale crossings plus crossing period.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module incr_meter
  import sig_pkg::*;
#(
  parameter int WIDTH     = c_sig_width,
  parameter int GATE_BITS = c_sig_gate_bits,
  parameter int PER_W     = c_sig_per_w
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     sample,
  output logic [GATE_BITS:0]   freq,
  output logic                 freq_valid,
  output logic [PER_W-1:0]     period,
  output logic                 period_valid
);

  meter_state_t r_state;
  meter_state_t w_state_nxt;
  logic         w_armed;
  logic         w_edge_now;
  logic         w_gate_last;
  logic         w_sample_unused;

  logic [GATE_BITS-1:0] r_gate_cnt;
  logic [GATE_BITS:0]   r_edge_cnt;
  logic [GATE_BITS:0]   r_freq;
  logic [PER_W-1:0]     r_since;
  logic [PER_W-1:0]     r_period;
  logic [PER_W-1:0]     w_since_inc;
  logic                 r_have_edge;
  logic                 r_freq_valid;
  logic                 r_period_valid;

  assign w_sample_unused = ^sample[WIDTH-2:0];

  edge_det u_edge_det (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (clear),
    .arm      (w_armed),
    .msb      (sample[WIDTH-1]),
    .edge_now (w_edge_now)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = PRIME;
    end else begin
      case (r_state)
        PRIME:   if (en) w_state_nxt = GATE;
        GATE:    w_state_nxt = GATE;
        default: w_state_nxt = PRIME;
      endcase
    end
  end

  always_comb begin
    w_armed = 1'b0;
    case (r_state)
      GATE:    w_armed = 1'b1;
      default: w_armed = 1'b0;
    endcase
  end

  assign w_gate_last = (r_gate_cnt == {GATE_BITS{1'b1}});
  // saturating since+1, shared by the period update and the running count
  assign w_since_inc = (r_since == {PER_W{1'b1}}) ? r_since : r_since + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate_cnt     <= '0;
      r_edge_cnt     <= '0;
      r_freq         <= '0;
      r_since        <= '0;
      r_period       <= '0;
      r_have_edge    <= 1'b0;
      r_freq_valid   <= 1'b0;
      r_period_valid <= 1'b0;
    end else if (clear) begin
      r_gate_cnt     <= '0;
      r_edge_cnt     <= '0;
      r_since        <= '0;
      r_have_edge    <= 1'b0;
      r_freq_valid   <= 1'b0;
      r_period_valid <= 1'b0;
    end else begin
      r_freq_valid   <= 1'b0;
      r_period_valid <= 1'b0;
      if (en && w_armed) begin
        r_gate_cnt <= r_gate_cnt + 1'b1;
        if (w_gate_last) begin
          r_freq       <= r_edge_cnt + {{GATE_BITS{1'b0}}, w_edge_now};
          r_freq_valid <= 1'b1;
          r_edge_cnt   <= '0;
        end else if (w_edge_now) begin
          r_edge_cnt <= r_edge_cnt + 1'b1;
        end

        if (w_edge_now) begin
          if (r_have_edge) begin
            r_period       <= w_since_inc;
            r_period_valid <= 1'b1;
          end
          r_since     <= '0;
          r_have_edge <= 1'b1;
        end else begin
          r_since <= w_since_inc;
        end
      end
    end
  end

  assign freq         = r_freq;
  assign freq_valid   = r_freq_valid;
  assign period       = r_period;
  assign period_valid = r_period_valid;

endmodule

`default_nettype wire

// File: tb/tb_incr_meter.sv
// ============================================================================
//  Module   : tb_incr_meter
//  Brief    : Directed self-checking bench for incr_meter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_incr_meter;

  logic        clk = 1'b0;
  logic        rst, en, clear;
  logic [7:0]  sample;
  logic [8:0]  freq, freq_b;
  logic        freq_valid, freq_valid_b;
  logic [15:0] period;
  logic        period_valid;
  logic [3:0]  period_b;
  logic        period_valid_b;

  always #5 clk = ~clk;

  incr_meter dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .sample(sample),
    .freq(freq), .freq_valid(freq_valid),
    .period(period), .period_valid(period_valid)
  );

  // narrow period counter instance for saturation
  incr_meter #(.WIDTH(8), .GATE_BITS(8), .PER_W(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .sample(sample),
    .freq(freq_b), .freq_valid(freq_valid_b),
    .period(period_b), .period_valid(period_valid_b)
  );

  int errors = 0;
  int checks = 0;
  int acc = 0;
  int acc_base, fv_cnt, pv_cnt, pv_b_cnt, fv_at;
  int last_freq, last_per, last_per_b;
  int freq_bad, per_bad, per_b_bad, off_bad;
  int exp_freq, exp_per, exp_per_b;
  logic [7:0] val;
  logic [3:0] pat = 4'b1001;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    acc_base = acc;
    fv_cnt = 0; pv_cnt = 0; pv_b_cnt = 0; fv_at = -1;
    last_freq = -1; last_per = -1; last_per_b = -1;
    freq_bad = 0; per_bad = 0; per_b_bad = 0; off_bad = 0;
  endtask

  task automatic tick();
    logic accepted;
    accepted = en && !clear && !rst;
    @(posedge clk);
    #1;
    if (accepted) acc++;
    if (freq_valid) begin
      fv_cnt++;
      last_freq = int'(freq);
      fv_at = acc - acc_base;
      if (int'(freq) != exp_freq) freq_bad++;
      if (!accepted || ((acc - acc_base) % 256) != 1) off_bad++;
    end
    if (period_valid) begin
      pv_cnt++;
      last_per = int'(period);
      if (int'(period) != exp_per) per_bad++;
    end
    if (period_valid_b) begin
      pv_b_cnt++;
      last_per_b = int'(period_b);
      if (int'(period_b) != exp_per_b) per_b_bad++;
    end
  endtask

  task automatic ramp(input int n, input logic [7:0] incr, input bit gapped);
    int got = 0;
    int p = 0;
    logic e;
    while (got < n) begin
      e = gapped ? pat[p % 4] : 1'b1;
      p++;
      sample = val;
      en = e;
      tick();
      if (e) begin
        val = val + incr;
        got++;
      end
    end
    en = 1'b0;
  endtask

  task automatic hold(input int n, input logic [7:0] s);
    for (int k = 0; k < n; k++) begin
      sample = s;
      en = 1'b1;
      tick();
    end
    en = 1'b0;
  endtask

  // en is held high on the clear cycle so the coincident sample is discarded
  task automatic do_clear();
    clear = 1'b1;
    en = 1'b1;
    tick();
    clear = 1'b0;
    en = 1'b0;
    clr_stats();
    val = 8'h00;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; sample = 8'h00; val = 8'h00;
    exp_freq = 0; exp_per = 0; exp_per_b = 0;
    clr_stats();
    tick();
    tick();
    chk("reset_freq", int'(freq), 0);
    chk("reset_freq_valid", int'(freq_valid), 0);
    chk("reset_period", int'(period), 0);
    chk("reset_period_valid", int'(period_valid), 0);
    rst = 1'b0;
    tick();
    clr_stats();

    // baseline ramp, increment 4
    exp_freq = 4; exp_per = 64; exp_per_b = 15;
    ramp(257, 8'd4, 1'b0);
    chk("s1_fv_cnt", fv_cnt, 1);
    chk("s1_fv_at", fv_at, 257);
    chk("s1_freq", last_freq, 4);
    chk("s1_pv_cnt", pv_cnt, 3);
    ramp(256, 8'd4, 1'b0);
    chk("s1_fv_cnt2", fv_cnt, 2);
    chk("s1_pv_cnt2", pv_cnt, 7);
    chk("s1_freq_bad", freq_bad, 0);
    chk("s1_per_bad", per_bad, 0);
    chk("s1_per_b_bad", per_b_bad, 0);
    chk("s1_off_bad", off_bad, 0);
    tick();
    chk("s1_idle_fv", int'(freq_valid), 0);
    chk("s1_hold_freq", int'(freq), 4);

    // zero increment
    do_clear();
    chk("s2_freq_held", int'(freq), 4);
    chk("s2_per_held", int'(period), 64);
    exp_freq = 0;
    hold(513, 8'h80);
    chk("s2_fv_cnt", fv_cnt, 2);
    chk("s2_freq", last_freq, 0);
    chk("s2_pv_cnt", pv_cnt, 0);
    hold(256, 8'h00);
    chk("s2_fv_cnt2", fv_cnt, 3);
    chk("s2_pv_cnt2", pv_cnt, 0);
    chk("s2_freq_bad", freq_bad, 0);
    chk("s2_off_bad", off_bad, 0);

    // gapped enable
    do_clear();
    exp_freq = 4; exp_per = 64;
    ramp(513, 8'd4, 1'b1);
    chk("s3_fv_cnt", fv_cnt, 2);
    chk("s3_freq", last_freq, 4);
    chk("s3_fv_at", fv_at, 513);
    chk("s3_pv_cnt", pv_cnt, 7);
    chk("s3_per_bad", per_bad, 0);
    chk("s3_freq_bad", freq_bad, 0);
    chk("s3_off_bad", off_bad, 0);

    // maximum rate, increment 128
    do_clear();
    exp_freq = 128; exp_per = 2; exp_per_b = 2;
    ramp(257, 8'd128, 1'b0);
    chk("s4_fv_cnt", fv_cnt, 1);
    chk("s4_freq", last_freq, 128);
    chk("s4_pv_cnt", pv_cnt, 127);
    chk("s4_per_bad", per_bad, 0);
    chk("s4_per_b_bad", per_b_bad, 0);

    // reset mid-gate
    do_clear();
    exp_freq = 4; exp_per = 64; exp_per_b = 15;
    ramp(99, 8'd4, 1'b0);
    sample = val; en = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    tick();
    chk("s5_rst_fv_cnt", fv_cnt, 0);
    chk("s5_rst_freq", int'(freq), 0);
    chk("s5_rst_period", int'(period), 0);
    clr_stats();
    val = 8'h00;
    ramp(257, 8'd4, 1'b0);
    chk("s5_rst_fv_at", fv_at, 257);
    chk("s5_rst_freq2", last_freq, 4);
    chk("s5_rst_period2", int'(period), 64);

    // clear mid-gate
    do_clear();
    ramp(99, 8'd4, 1'b0);
    do_clear();
    chk("s5_clr_freq", int'(freq), 4);
    chk("s5_clr_period", int'(period), 64);
    ramp(257, 8'd4, 1'b0);
    chk("s5_clr_fv_cnt", fv_cnt, 1);
    chk("s5_clr_fv_at", fv_at, 257);
    chk("s5_clr_freq_bad", freq_bad, 0);

    // period saturation: square wave, crossings 40 samples apart
    do_clear();
    exp_per = 40; exp_per_b = 15;
    for (int k = 0; k < 200; k++) begin
      sample = (((k / 20) % 2) == 1) ? 8'h80 : 8'h00;
      en = 1'b1;
      tick();
    end
    en = 1'b0;
    chk("s6_pv_cnt", pv_cnt, 4);
    chk("s6_period", last_per, 40);
    chk("s6_pv_b_cnt", pv_b_cnt, 4);
    chk("s6_period_b", last_per_b, 15);
    chk("s6_per_b_bad", per_b_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/incr_meter.md
Name: incr_meter

Overview:
- Measures the step rate of a periodic sample stream, such as a ROM-driven sine or a raw phase ramp.
- Recovers the effective phase increment from the stream: it counts rising mid-scale crossings (MSB 0->1) over a fixed gate of 2^GATE_BITS accepted samples.
- Also measures the sample-count period between consecutive crossings.
- Sits on the output side of the signal generator as its self-check / measurement companion. Its result is directly comparable to the generator's programmed increment.

Parameters:
- WIDTH, 8, sample width in bits. The crossing detector uses bit WIDTH-1.
- GATE_BITS, 8, gate length is 2^GATE_BITS accepted samples.
- PER_W, 16, width of the period counter and output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- en  in  1  sample valid. The sample is accepted on a posedge where en=1.
- clear  in  1  synchronous restart of the measurement; does not clear outputs.
- sample  in  WIDTH  input sample, unsigned, mid-scale = 2^(WIDTH-1).
- freq  out  GATE_BITS+1  rising crossings counted in the last completed gate.
- freq_valid  out  1  one-cycle pulse when freq updates.
- period  out  PER_W  accepted samples between the last two rising crossings.
- period_valid  out  1  one-cycle pulse when period updates.

Behaviour:
- Reset rst: synchronous, active-high; clock clk. rst has priority over clear and en.
- Reset values:
  - freq=0, freq_valid=0, period=0, period_valid=0.
  - Internal state: state=PRIME, edge_cnt=0, gate_cnt=0, since=0, have_edge=0.
- Edge definition: a rising crossing is prev_msb=0 and sample[WIDTH-1]=1 on an accepted sample.
- Only accepted samples (en=1) advance any counter or update prev_msb. With en=0 all state holds and the valid pulses are 0.
- FSM states:
  - PRIME: the first accepted sample only loads prev_msb. No edge is possible, gate_cnt stays 0. Transition to GATE.
  - GATE: each accepted sample increments gate_cnt, mod 2^GATE_BITS. A detected edge increments edge_cnt.
    - On the accepted sample with gate_cnt = 2^GATE_BITS-1 (the gate's last sample): freq <= edge_cnt + edge_now, freq_valid <= 1, edge_cnt <= 0, gate_cnt wraps to 0.
    - The next gate starts with the very next accepted sample; there are no gaps.
- freq latency: 1 clock. freq is visible on the clock after the gate's final sample is accepted.
- freq width: GATE_BITS+1 bits, so the theoretical maximum of 2^(GATE_BITS-1) never overflows. edge_cnt uses the same width.
- Period measurement:
  - since counts accepted samples from the last edge, including the current sample. It saturates at 2^PER_W-1 and never wraps.
  - On an edge with have_edge=1: period <= since+1 (saturating), period_valid <= 1.
  - On every edge: since <= 0, have_edge <= 1.
  - The first edge after reset or clear sets only have_edge; no period pulse.
- Valid pulses are single-cycle and deassert the following clock unless re-triggered. freq_valid and period_valid may assert on the same clock.
- clear=1 on a clock:
  - Effect: state <= PRIME; edge_cnt, gate_cnt, since and have_edge all <= 0; both valid pulses <= 0.
  - freq and period hold their last values.
  - clear takes priority over a coincident accepted sample; that sample is discarded.
- Reset or clear mid-gate discards the partial gate; no freq_valid is issued for it.
- Constant input (e.g. generator increment 0): no edges. freq_valid still pulses every 2^GATE_BITS accepted samples, with freq=0. period_valid never pulses.
- Outputs are all registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package sig_pkg holds:
  - the state enum typedef {PRIME, GATE};
  - the default-width localparams shared with the generator (WIDTH=8).
- One natural sub-module: edge_det. It is a registered MSB rising-edge detector with en qualification and a prime/clear input, and outputs edge_now.
- Counters and the FSM live in incr_meter.

Test Plan:
1. Baseline ramp: defaults; en=1; sample = ramp starting at 0, step incr=4 per accepted sample, mod 256.
   -> The first freq_valid arrives 1 clock after the 257th accepted sample (1 prime + 256 gate) with freq=4.
   -> period_valid fires with period=64 from the second crossing on.
2. Zero increment: sample held at 0x80 (then at 0x00).
   -> freq_valid every 256 accepted samples with freq=0.
   -> period_valid never asserts.
3. Gapped enable: repeat scenario 1 with en toggling 1,0,0,1 pseudo-randomly.
   -> Identical freq=4 and period=64. Pulses occur only after accepted samples, and the count of accepted samples per gate is exactly 256.
4. Maximum rate: incr=128 ramp (alternating 0x00/0x80).
   -> freq=128 (no overflow in the 9-bit output); period=2.
5. Mid-gate disruption: ramp incr=4, assert rst at accepted sample 100, later assert clear at accepted sample 100 of a new run.
   -> No freq_valid for the partial gate.
   -> After rst, freq/period = 0; after clear, freq/period hold their previous values.
   -> The next freq=4 arrives 257 accepted samples after the restart.
6. Period saturation: PER_W=4; a slow ramp with crossings 40 samples apart.
   -> period=15 (saturated) on each crossing after the first.
